// File: rtl/mips_pkg.sv
// Shared MIPS-subset definitions used by the fetch stage and its next-PC selector.
package mips_pkg;

    localparam int INSTR_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_t;

    // Word-aligned, sign-extended branch displacement from the 16-bit immediate.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_unit_npc_sel.sv
// Next-PC selection for a retiring instruction: jump beats taken branch beats fall-through.
module npc_sel
    import mips_pkg::*;
(
    input  logic [31:0]        pc_plus4,
    input  logic [INSTR_W-1:0] instr,
    input  logic               pcsrc,
    input  logic               jump,
    output logic [31:0]        next_pc
);

    logic [31:0] w_jump_target;
    logic [31:0] w_branch_target;
    logic        w_unused_op;

    assign w_jump_target   = {pc_plus4[31:28], instr[25:0], 2'b00};
    assign w_branch_target = pc_plus4 + branch_offset(instr[15:0]);
    // Opcode bits are decoded by the controller, not here.
    assign w_unused_op     = &instr[31:26];

    always_comb begin
        next_pc = pc_plus4;
        if (jump) begin
            next_pc = w_jump_target;
        end else if (pcsrc) begin
            next_pc = w_branch_target;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over req/ack, holds the word for decode, counts retires.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          CNT_W    = 32
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [5:0]         op,
    output logic [5:0]         funct,
    output logic [31:0]        pc_plus4,
    output logic               instr_valid,
    input  logic               instr_ready,
    input  logic               pcsrc,
    input  logic               jump,
    output logic [CNT_W-1:0]   instret
);

    fetch_state_t       r_state;
    logic [31:0]        r_pc;
    logic [INSTR_W-1:0] r_instr;
    logic [CNT_W-1:0]   r_instret;
    logic [31:0]        w_pc_plus4;
    logic [31:0]        w_next_pc;

    assign w_pc_plus4 = r_pc + 32'd4;

    npc_sel u_npc_sel (
        .pc_plus4 (w_pc_plus4),
        .instr    (r_instr),
        .pcsrc    (pcsrc),
        .jump     (jump),
        .next_pc  (w_next_pc)
    );

    // Reset wins over ack and retire alike, abandoning any fetch in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= FETCH;
            r_pc      <= RESET_PC;
            r_instr   <= '0;
            r_instret <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ack) begin
                        r_instr <= imem_rdata;
                        r_state <= HOLD;
                    end
                end
                HOLD: begin
                    if (instr_ready) begin
                        r_pc      <= w_next_pc;
                        r_instret <= r_instret + CNT_W'(1);
                        r_state   <= FETCH;
                    end
                end
                default: r_state <= FETCH;
            endcase
        end
    end

    assign imem_req    = (r_state == FETCH);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_state == HOLD);
    assign instr       = r_instr;
    assign op          = r_instr[31:26];
    assign funct       = r_instr[5:0];
    assign pc_plus4    = w_pc_plus4;
    assign instret     = r_instret;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs change and outputs are sampled on the falling edge.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [5:0]  op;
    logic [5:0]  funct;
    logic [31:0] pc_plus4;
    logic        instr_valid;
    logic        instr_ready;
    logic        pcsrc;
    logic        jump;
    logic [31:0] instret;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .op          (op),
        .funct       (funct),
        .pc_plus4    (pc_plus4),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .pcsrc       (pcsrc),
        .jump        (jump),
        .instret     (instret)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("check %-16s observed %h expected %h", tag, obs, exp);
    endtask

    // Present one word with ack for a single cycle; leaves the DUT in HOLD.
    task automatic do_fetch(input logic [31:0] word, input logic [31:0] addr);
        chk("fetch_req", {31'd0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, addr);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
        chk("hold_valid", {31'd0, instr_valid}, 32'd1);
    endtask

    task automatic do_retire(input logic j, input logic b);
        instr_ready = 1'b1;
        jump        = j;
        pcsrc       = b;
        @(negedge clk);
        instr_ready = 1'b0;
        jump        = 1'b0;
        pcsrc       = 1'b0;
    endtask

    initial begin
        reset = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
        instr_ready = 1'b0; pcsrc = 1'b0; jump = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // 1: idle after reset with no ack
        for (int i = 0; i < 5; i++) begin
            chk("rst_req", {31'd0, imem_req}, 32'd1);
            chk("rst_addr", imem_addr, 32'h0);
            chk("rst_valid", {31'd0, instr_valid}, 32'd0);
            chk("rst_instret", instret, 32'd0);
            @(negedge clk);
        end

        // 2: addi at 0, retired immediately
        instr_ready = 1'b1;
        do_fetch(32'h2008_0005, 32'h0);
        chk("addi_op", {26'd0, op}, 32'h08);
        chk("addi_instr", instr, 32'h2008_0005);
        @(negedge clk);
        instr_ready = 1'b0;
        chk("addi_next", imem_addr, 32'h4);
        chk("addi_instret", instret, 32'd1);

        // walk to pc 0x10 with plain instructions
        for (int a = 4; a < 16; a += 4) begin
            do_fetch(32'h0000_0020, 32'(a));
            do_retire(1'b0, 1'b0);
        end

        // 3: beq taken then not taken at pc 0x10
        do_fetch(32'h1109_0002, 32'h10);
        chk("beq_op", {26'd0, op}, 32'h04);
        chk("beq_funct", {26'd0, funct}, 32'h02);
        chk("beq_pc4", pc_plus4, 32'h14);
        do_retire(1'b0, 1'b1);
        chk("beq_taken", imem_addr, 32'h1C);
        do_fetch(32'h0800_0004, 32'h1C);
        do_retire(1'b1, 1'b0);
        chk("j_back", imem_addr, 32'h10);
        do_fetch(32'h1109_0002, 32'h10);
        do_retire(1'b0, 1'b0);
        chk("beq_not", imem_addr, 32'h14);
        do_fetch(32'h0800_0004, 32'h14);
        do_retire(1'b1, 1'b0);

        // 4: jump wins over pcsrc
        do_fetch(32'h0800_0040, 32'h10);
        do_retire(1'b1, 1'b1);
        chk("jump_addr", imem_addr, 32'h100);
        chk("jump_instret", instret, 32'd9);

        // 5: ack delayed three cycles, then ready low for four
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("wait_req", {31'd0, imem_req}, 32'd1);
            chk("wait_addr", imem_addr, 32'h100);
        end
        do_fetch(32'h0000_0020, 32'h100);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("bp_instr", instr, 32'h0000_0020);
            chk("bp_pc4", pc_plus4, 32'h104);
            chk("bp_instret", instret, 32'd9);
            chk("bp_req", {31'd0, imem_req}, 32'd0);
        end
        do_retire(1'b0, 1'b0);
        chk("bp_next", imem_addr, 32'h104);
        chk("bp_instret2", instret, 32'd10);

        // 6: branch back to 0xFFFFFFFC, then wrap to 0
        do_fetch(32'h1000_FFBD, 32'h104);
        do_retire(1'b0, 1'b1);
        chk("neg_branch", imem_addr, 32'hFFFF_FFFC);
        do_fetch(32'h0000_0020, 32'hFFFF_FFFC);
        chk("wrap_pc4", pc_plus4, 32'h0);
        do_retire(1'b0, 1'b0);
        chk("wrap_addr", imem_addr, 32'h0);
        chk("wrap_instret", instret, 32'd12);

        // reset collides with retire in HOLD
        do_fetch(32'h0000_0020, 32'h0);
        reset = 1'b1;
        instr_ready = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        instr_ready = 1'b0;
        chk("rr_addr", imem_addr, 32'h0);
        chk("rr_instret", instret, 32'd0);
        chk("rr_valid", {31'd0, instr_valid}, 32'd0);
        chk("rr_req", {31'd0, imem_req}, 32'd1);
        chk("rr_instr", instr, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
